layer_mac_sequencer: RTL

- Control FSM that sequences one shared Q8.8 MAC datapath through a fully connected generator layer.
- Default layer is 64 inputs to 256 neurons, matching the layer-1 generator.
- Generates input index, weight/bias ROM addresses, accumulator clear/enable strobes and output writeback strobes; owns the start/busy/done handshake seen by the top-level GAN controller.
- Datapath (MAC, ROMs, saturation, output register file) is external.

---
 rtl/gan_pkg.sv | 33 +++
 rtl/valid_delay_line.sv | 35 +++
 rtl/layer_mac_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gan_pkg.sv
// Shared definitions for the GAN generator: Q8.8 data format, layer
// dimensions and the layer sequencer state encoding.
package gan_pkg;

  // Q8.8 fixed-point format used by the MAC datapath
  localparam int Q_W    = 16;
  localparam int Q_FRAC = 8;

  // Generator layer dimensions (inputs -> neurons)
  localparam int L1_N_IN  = 64;
  localparam int L1_N_OUT = 256;
  localparam int L2_N_IN  = 256;
  localparam int L2_N_OUT = 512;
  localparam int L3_N_IN  = 512;
  localparam int L3_N_OUT = 784;

  // Sequencer state encoding, exported so the top-level controller can
  // decode debug state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // Index width that never collapses to zero bits for a count of one
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage shift register that aligns the address-issue flag with the
// moment its read data reaches the MAC.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // Shift the issue flag one stage per cycle
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset empties the whole line
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {DEPTH{1'b0}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/layer_mac_sequencer.sv
// Control FSM that walks one shared MAC datapath through a fully
// connected layer: clear, N_IN accumulates, read-latency drain, writeback.
module layer_mac_sequencer
  import gan_pkg::*;
#(
  parameter int N_IN   = L1_N_IN,
  parameter int N_OUT  = L1_N_OUT,
  parameter int RD_LAT = 1,
  parameter int IDX_W  = safe_clog2(N_IN),
  parameter int NEU_W  = safe_clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       in_idx,
  output logic [NEU_W+IDX_W-1:0] w_addr,
  output logic [NEU_W-1:0]       b_addr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   wr_en,
  output logic [NEU_W-1:0]       wr_idx
);

  localparam int AW    = NEU_W + IDX_W;
  localparam int LAT_W = 3;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_IN - 1);
  localparam logic [NEU_W-1:0] NEU_LAST  = NEU_W'(N_OUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [AW-1:0]    BASE_STEP = AW'(N_IN);

  seq_state_e       state_q, state_d;
  logic [NEU_W-1:0] neuron_q, neuron_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             issue_s;

  // Next-state and counter update; the weight base advances by N_IN per
  // neuron so no multiplier is needed for neuron*N_IN.
  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    in_idx_d = in_idx_q;
    base_d   = base_q;
    lat_d    = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          neuron_d = {NEU_W{1'b0}};
          in_idx_d = {IDX_W{1'b0}};
          base_d   = {AW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        in_idx_d = {IDX_W{1'b0}};
        lat_d    = {LAT_W{1'b0}};
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (in_idx_q == IDX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          in_idx_d = in_idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        // Drain length equals RD_LAT, so the delay line is empty at WRITE
        if (lat_q == LAT_LAST) begin
          state_d = ST_WRITE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_WRITE: begin
        if (neuron_q == NEU_LAST) begin
          state_d = ST_DONE;
        end else begin
          neuron_d = neuron_q + NEU_W'(1);
          base_d   = base_q + BASE_STEP;
          in_idx_d = {IDX_W{1'b0}};
          state_d  = ST_CLEAR;
        end
      end
      ST_DONE: begin
        neuron_d = {NEU_W{1'b0}};
        in_idx_d = {IDX_W{1'b0}};
        base_d   = {AW{1'b0}};
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      neuron_q <= {NEU_W{1'b0}};
      in_idx_q <= {IDX_W{1'b0}};
      base_q   <= {AW{1'b0}};
      lat_q    <= {LAT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      in_idx_q <= in_idx_d;
      base_q   <= base_d;
      lat_q    <= lat_d;
    end
  end

  assign issue_s = (state_q == ST_RUN);

  valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_valid_delay_line (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_s),
    .out_valid (mac_en)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign mac_clr = (state_q == ST_CLEAR);
  assign wr_en   = (state_q == ST_WRITE);
  assign in_idx  = in_idx_q;
  assign w_addr  = base_q + {{NEU_W{1'b0}}, in_idx_q};
  assign b_addr  = neuron_q;
  assign wr_idx  = neuron_q;

endmodule
